// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
//
// Owns the shared external memory bus (cartridge ROM/RAM, VRAM, WRAM, OAM)
// and hands it to one of three masters: the CPU, the GBC HDMA/GDMA engine
// and the FF46 OAM DMA engine. Priority is HDMA > OAM > CPU. Every change
// of bus owner passes through an idle gap of GAP_CYCLES ce cycles so that
// no two masters ever drive the bus in consecutive cycles.
//
// DMA bytes (HDMA and OAM alike) run as a 4-phase sequence, one phase per
// ce: phases 0-1 address the source (read data captured at the end of
// phase 1), phases 2-3 address the target, and phase 3 writes.
//
// Build option:
//   OAM_DMA_EN  defined   -> FF46 register, OAM DMA engine and S_OAM present.
//               undefined -> no OAM logic, reg_dout reads 8'hFF, FF46 writes
//                            are ignored and every CPU access is arbitrated
//                            (no HRAM stall exemption).
//
// bus_owner is a direct copy of the FSM state register (the state encoding
// is the owner code), so it also serves as the state debug view.
//
// CPU handshake: the CPU presents cpu_req with cpu_addr/cpu_wr/cpu_dout and
// keeps all of them stable while cpu_stall is 1; the access takes effect on
// a ce cycle where cpu_req=1 and cpu_stall=0, and the CPU may change or drop
// the request only after such a cycle.

module dma_bus_arbiter #(
    parameter int OAM_LEN    = 160,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_stall,
    input  logic        reg_sel,
    input  logic        reg_wr,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    input  logic        hdma_active,
    input  logic        hdma_rd,
    input  logic [15:0] hdma_source_addr,
    input  logic [15:0] hdma_target_addr,
    output logic [15:0] bus_addr,
    output logic        bus_wr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic [1:0]  bus_owner,
    output logic        oam_dma_active
);

    // State encoding doubles as the bus_owner code.
    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_HDMA = 2'd1,
        S_OAM  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [1:0]  GAP_LAST = 2'(GAP_CYCLES - 1);
    localparam logic [15:0] BUS_IDLE = 16'hFFFF;

    // Arbiter core registers
    state_t      state_q, state_d;
    state_t      target_q, target_d;    // owner to hand the bus to when the gap ends
    logic [1:0]  gap_cnt_q, gap_cnt_d;  // ce cycles already spent in the gap
    logic [1:0]  phase_q, phase_d;      // byte phase, shared by HDMA and OAM
    logic [7:0]  data_q, data_d;        // byte captured at the end of phase 1

    // Signals the core needs from the OAM engine (constant when it is absent)
    logic        pending;        // OAM transfer waiting or running
    logic        reg_write;      // FF46 write strobe (ce applied where used)
    logic        oam_last_done;  // final OAM byte completes this cycle

`ifdef OAM_DMA_EN
    localparam logic [7:0] OAM_LAST = 8'(OAM_LEN - 1);

    // OAM engine registers
    logic [7:0]  src_hi_q, src_hi_d;    // FF46 value: source page
    logic [7:0]  idx_q, idx_d;          // byte index within the transfer
    logic        pending_q, pending_d;

    logic [7:0]  src_eff;               // source page after echo-RAM folding
    logic [15:0] oam_source;
    logic [15:0] oam_target;
    logic        cpu_in_hram;

    assign reg_write = reg_sel & reg_wr;
    assign pending   = pending_q;

    // Pages E0-FF are echo RAM; fold them onto C0-DF.
    assign src_eff    = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;
    assign oam_source = {src_eff, idx_q};
    assign oam_target = 16'hFE00 + {8'h00, idx_q};

    // A restart write or a preemption both keep the final byte from completing.
    assign oam_last_done = (state_q == S_OAM) && !hdma_active && !reg_write &&
                           (phase_q == 2'd3) && (idx_q == OAM_LAST);

    // HRAM (FF80-FFFE) is wired to the CPU directly and never waits.
    assign cpu_in_hram = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);

    assign cpu_stall      = cpu_req && (state_q != S_CPU) && !cpu_in_hram;
    assign reg_dout       = src_hi_q;
    assign oam_dma_active = pending_q;

    // OAM engine next-state: FF46 writes restart, byte completion advances idx.
    always_comb begin
        src_hi_d  = src_hi_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        if (ce) begin
            if (reg_write) begin
                src_hi_d  = reg_din;
                idx_d     = 8'h00;
                pending_d = 1'b1;
            end else if (oam_last_done) begin
                idx_d     = 8'h00;
                pending_d = 1'b0;
            end else if ((state_q == S_OAM) && !hdma_active && (phase_q == 2'd3)) begin
                idx_d = idx_q + 8'd1;
            end
        end
    end

    // OAM engine registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_hi_q  <= 8'hFF;
            idx_q     <= 8'h00;
            pending_q <= 1'b0;
        end else begin
            src_hi_q  <= src_hi_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end
`else
    logic unused_reg_inputs;

    assign reg_write = 1'b0;
    assign pending   = 1'b0;
    // S_OAM cannot be entered; should it ever be, leave it at once.
    assign oam_last_done = (state_q == S_OAM);

    assign unused_reg_inputs = ^{reg_sel, reg_wr, reg_din, 8'(OAM_LEN)};

    assign cpu_stall      = cpu_req && (state_q != S_CPU);
    assign reg_dout       = 8'hFF;
    assign oam_dma_active = 1'b0;
`endif

    assign bus_owner = state_q;

    // Arbiter FSM next-state: ownership changes, gap counting, byte phases.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        gap_cnt_d = gap_cnt_q;
        phase_d   = phase_q;
        data_d    = data_q;
        if (ce) begin
            case (state_q)
                S_CPU: begin
                    if (hdma_active) begin
                        state_d   = S_GAP;
                        target_d  = S_HDMA;
                        gap_cnt_d = 2'd0;
                        phase_d   = 2'd0;
                    end else if (pending) begin
                        state_d   = S_GAP;
                        target_d  = S_OAM;
                        gap_cnt_d = 2'd0;
                        phase_d   = 2'd0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d   = target_q;
                        gap_cnt_d = 2'd0;
                        phase_d   = 2'd0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 2'd1;
                    end
                end
                S_HDMA: begin
                    if (!hdma_active) begin
                        state_d   = S_GAP;
                        target_d  = pending ? S_OAM : S_CPU;
                        gap_cnt_d = 2'd0;
                        phase_d   = 2'd0;
                    end else if (hdma_rd) begin
                        phase_d = phase_q + 2'd1;
                        if (phase_q == 2'd1) begin
                            data_d = bus_din;
                        end
                    end else begin
                        // Phase realigns to the next hdma_rd rise.
                        phase_d = 2'd0;
                    end
                end
                S_OAM: begin
                    if (hdma_active) begin
                        // Preempt: the interrupted byte restarts at phase 0.
                        state_d   = S_GAP;
                        target_d  = S_HDMA;
                        gap_cnt_d = 2'd0;
                        phase_d   = 2'd0;
                    end else if (reg_write) begin
                        // Restart: abandon the in-flight byte.
                        phase_d = 2'd0;
                    end else if (oam_last_done) begin
                        state_d   = S_GAP;
                        target_d  = S_CPU;
                        gap_cnt_d = 2'd0;
                        phase_d   = 2'd0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        if (phase_q == 2'd1) begin
                            data_d = bus_din;
                        end
                    end
                end
                default: begin
                    state_d = S_CPU;
                end
            endcase
        end
    end

    // Arbiter FSM and data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_CPU;
            target_q  <= S_CPU;
            gap_cnt_q <= 2'd0;
            phase_q   <= 2'd0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            gap_cnt_q <= gap_cnt_d;
            phase_q   <= phase_d;
            data_q    <= data_d;
        end
    end

    // Bus drive: purely a function of owner, phase and the data register.
    always_comb begin
        bus_addr = BUS_IDLE;
        bus_wr   = 1'b0;
        bus_dout = data_q;
        case (state_q)
            S_CPU: begin
                bus_addr = cpu_addr;
                bus_dout = cpu_dout;
                bus_wr   = cpu_req & cpu_wr;
            end
            S_HDMA: begin
                if (hdma_rd) begin
                    bus_addr = phase_q[1] ? hdma_target_addr : hdma_source_addr;
                    bus_wr   = (phase_q == 2'd3);
                end
            end
            S_OAM: begin
`ifdef OAM_DMA_EN
                bus_addr = phase_q[1] ? oam_target : oam_source;
                bus_wr   = (phase_q == 2'd3);
`endif
            end
            default: begin
                bus_addr = BUS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Testbench for dma_bus_arbiter: directed sequence with randomized data,
// expected bus traffic computed from byte index / phase arithmetic.

module tb_dma_bus_arbiter;

    // Clock / reset and DUT signals
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_stall;
    logic        reg_sel = 1'b0;
    logic        reg_wr = 1'b0;
    logic [7:0]  reg_din = 8'h00;
    logic [7:0]  reg_dout;
    logic        hdma_active = 1'b0;
    logic        hdma_rd = 1'b0;
    logic [15:0] hdma_source_addr = 16'h0000;
    logic [15:0] hdma_target_addr = 16'h0000;
    logic [15:0] bus_addr;
    logic        bus_wr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din = 8'h00;
    logic [1:0]  bus_owner;
    logic        oam_dma_active;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    dma_bus_arbiter #(.OAM_LEN(160), .GAP_CYCLES(1)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_stall(cpu_stall),
        .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_din(reg_din), .reg_dout(reg_dout),
        .hdma_active(hdma_active), .hdma_rd(hdma_rd),
        .hdma_source_addr(hdma_source_addr), .hdma_target_addr(hdma_target_addr),
        .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_dout(bus_dout), .bus_din(bus_din),
        .bus_owner(bus_owner), .oam_dma_active(oam_dma_active)
    );

    // Scoreboard comparison
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference rules
    function automatic logic [7:0] echo_hi(input logic [7:0] s);
        return (s >= 8'hE0) ? (s - 8'h20) : s;
    endfunction

    function automatic logic in_hram(input logic [15:0] a);
        return (a >= 16'hFF80) && (a <= 16'hFFFE);
    endfunction

    function automatic logic exp_stall_gap(input logic [15:0] a);
`ifdef OAM_DMA_EN
        return !in_hram(a);
`else
        return 1'b1;
`endif
    endfunction

    // Driver helpers: inputs change 1 time unit after posedge, checks 1 later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_gap(input string tag);
        settle();
        check({tag, "_owner"}, 32'(bus_owner), 32'd3);
        check({tag, "_wr"}, 32'(bus_wr), 32'd0);
        check({tag, "_addr"}, 32'(bus_addr), 32'hFFFF);
    endtask

    // One HDMA byte with random addresses and read data
    task automatic hdma_byte();
        logic [15:0] s;
        logic [15:0] t;
        logic [7:0]  din;
        for (int ph = 0; ph < 4; ph++) begin
            s = 16'($urandom);
            t = 16'($urandom);
            din = 8'($urandom);
            hdma_source_addr = s;
            hdma_target_addr = t;
            bus_din = din;
            hdma_rd = 1'b1;
            settle();
            check("hdma_owner", 32'(bus_owner), 32'd1);
            check("hdma_addr", 32'(bus_addr), 32'((ph < 2) ? s : t));
            check("hdma_wr", 32'(bus_wr), 32'(ph == 3));
            if (ph == 1) exp_q.push_back(din);
            if (ph == 3 && exp_q.size() != 0) check("hdma_dout", 32'(bus_dout), 32'(exp_q.pop_front()));
            tick();
        end
        hdma_rd = 1'b0;
    endtask

    // One OAM phase: expected address from page/index arithmetic
    task automatic oam_phase(input logic [7:0] src, input int idx, input int ph);
        logic [15:0] ea;
        logic [15:0] ca;
        logic [7:0]  din;
        ea = (ph < 2) ? {echo_hi(src), 8'(idx)} : (16'hFE00 + 16'(idx));
        ca = (idx % 2 == 0) ? 16'hFF90 : 16'hC000;
        cpu_req = 1'b1;
        cpu_wr = 1'b0;
        cpu_addr = ca;
        din = 8'($urandom);
        bus_din = din;
        if (idx == 5 && ph == 2) begin
            ce = 1'b0;
            settle();
            check("oam_noce_addr", 32'(bus_addr), 32'(ea));
            tick();
            settle();
            check("oam_noce_owner", 32'(bus_owner), 32'd2);
            check("oam_noce_addr2", 32'(bus_addr), 32'(ea));
            ce = 1'b1;
        end
        settle();
        check("oam_owner", 32'(bus_owner), 32'd2);
        check("oam_addr", 32'(bus_addr), 32'(ea));
        check("oam_wr", 32'(bus_wr), 32'(ph == 3));
        check("oam_active", 32'(oam_dma_active), 32'd1);
        check("oam_stall", 32'(cpu_stall), 32'(!in_hram(ca)));
        if (ph == 1) exp_q.push_back(din);
        if (ph == 3 && exp_q.size() != 0) check("oam_dout", 32'(bus_dout), 32'(exp_q.pop_front()));
        tick();
    endtask

    task automatic oam_run(input logic [7:0] src, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            for (int ph = 0; ph < 4; ph++) oam_phase(src, i, ph);
        end
    endtask

    // FF46 write from S_CPU, then the CPU cycle and the gap
    task automatic start_oam(input logic [7:0] src);
        cpu_req = 1'b0;
        reg_sel = 1'b1;
        reg_wr = 1'b1;
        reg_din = src;
        ce = 1'b1;
        settle();
        check("ff46_owner_cpu", 32'(bus_owner), 32'd0);
        tick();
        reg_sel = 1'b0;
        reg_wr = 1'b0;
        settle();
        check("ff46_active", 32'(oam_dma_active), 32'd1);
        check("ff46_readback", 32'(reg_dout), 32'(src));
        check("ff46_still_cpu", 32'(bus_owner), 32'd0);
        tick();
        expect_gap("oam_enter_gap");
        tick();
    endtask

    task automatic finish_oam();
        expect_gap("oam_exit_gap");
        check("oam_done_inactive", 32'(oam_dma_active), 32'd0);
        tick();
        settle();
        check("oam_back_cpu", 32'(bus_owner), 32'd0);
        cpu_req = 1'b0;
    endtask

    // Watchdog: the sequence is fixed-length, this only guards against a hang
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] stall_addrs [6];
        logic [15:0] a;
        logic [7:0]  d;
        logic        r;
        logic        w;
        logic [7:0]  s1;
        logic [7:0]  s2;
        stall_addrs = '{16'hC000, 16'hFF7F, 16'hFF80, 16'hFF90, 16'hFFFE, 16'hFFFF};

        // Reset state
        #2;
        check("rst_owner", 32'(bus_owner), 32'd0);
        check("rst_wr", 32'(bus_wr), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_active", 32'(oam_dma_active), 32'd0);
        check("rst_reg_dout", 32'(reg_dout), 32'hFF);
        tick();
        reset_n = 1'b1;
        ce = 1'b1;
        settle();
        check("post_rst_owner", 32'(bus_owner), 32'd0);
        tick();

        // CPU pass-through with random traffic and ce
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom);
            d = 8'($urandom);
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            cpu_addr = a;
            cpu_dout = d;
            cpu_req = r;
            cpu_wr = w;
            ce = 1'($urandom_range(0, 1));
            settle();
            check("cpu_bus_addr", 32'(bus_addr), 32'(a));
            check("cpu_bus_dout", 32'(bus_dout), 32'(d));
            check("cpu_bus_wr", 32'(bus_wr), 32'(r & w));
            check("cpu_no_stall", 32'(cpu_stall), 32'd0);
            check("cpu_owner", 32'(bus_owner), 32'd0);
            tick();
        end
        cpu_req = 1'b0;
        cpu_wr = 1'b0;
        ce = 1'b1;

        // HDMA takeover: 1 ce to the gap, GAP_CYCLES ce more to ownership
        hdma_active = 1'b1;
        settle();
        check("hdma_req_still_cpu", 32'(bus_owner), 32'd0);
        tick();
        expect_gap("hdma_gap");
        ce = 1'b0;
        cpu_req = 1'b1;
        foreach (stall_addrs[k]) begin
            cpu_addr = stall_addrs[k];
            settle();
            check("gap_stall", 32'(cpu_stall), 32'(exp_stall_gap(stall_addrs[k])));
            tick();
        end
        settle();
        check("gap_hold_noce", 32'(bus_owner), 32'd3);
        cpu_req = 1'b0;
        ce = 1'b1;
        tick();
        settle();
        check("hdma_owned", 32'(bus_owner), 32'd1);
        check("hdma_idle_wr", 32'(bus_wr), 32'd0);
        // Aborted byte: one phase then hdma_rd low realigns the phase
        hdma_rd = 1'b1;
        tick();
        hdma_rd = 1'b0;
        settle();
        check("hdma_rd_low_wr", 32'(bus_wr), 32'd0);
        tick();
        for (int n = 0; n < 3; n++) hdma_byte();
        hdma_active = 1'b0;
        settle();
        check("hdma_fall_owner", 32'(bus_owner), 32'd1);
        tick();
        expect_gap("hdma_exit_gap");
        tick();
        settle();
        check("hdma_back_cpu", 32'(bus_owner), 32'd0);

        // Asynchronous reset in the middle of an HDMA byte
        hdma_active = 1'b1;
        tick();
        tick();
`ifdef OAM_DMA_EN
        reg_sel = 1'b1;
        reg_wr = 1'b1;
        reg_din = 8'h5A;
        tick();
        reg_sel = 1'b0;
        reg_wr = 1'b0;
        settle();
        check("mid_hdma_pending", 32'(oam_dma_active), 32'd1);
        check("mid_hdma_reg", 32'(reg_dout), 32'h5A);
`endif
        hdma_rd = 1'b1;
        tick();
        tick();
        cpu_req = 1'b1;
        cpu_wr = 1'b0;
        cpu_addr = 16'hC000;
        reset_n = 1'b0;
        settle();
        check("arst_owner", 32'(bus_owner), 32'd0);
        check("arst_wr", 32'(bus_wr), 32'd0);
        check("arst_stall", 32'(cpu_stall), 32'd0);
        check("arst_active", 32'(oam_dma_active), 32'd0);
        check("arst_reg_dout", 32'(reg_dout), 32'hFF);
        check("arst_addr", 32'(bus_addr), 32'hC000);
        hdma_active = 1'b0;
        hdma_rd = 1'b0;
        cpu_req = 1'b0;
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        settle();
        check("arst_release_owner", 32'(bus_owner), 32'd0);
        check("arst_no_pending", 32'(oam_dma_active), 32'd0);
        tick();

`ifdef OAM_DMA_EN
        // Full transfer from C1xx
        start_oam(8'hC1);
        oam_run(8'hC1, 0, 159);
        finish_oam();
        tick();

        // Echo page FE -> DE, preempted by HDMA at idx 40 phase 2
        start_oam(8'hFE);
        oam_run(8'hFE, 0, 39);
        oam_phase(8'hFE, 40, 0);
        oam_phase(8'hFE, 40, 1);
        hdma_active = 1'b1;
        oam_phase(8'hFE, 40, 2);
        exp_q.delete();
        expect_gap("preempt_gap");
        tick();
        settle();
        check("preempt_hdma_owner", 32'(bus_owner), 32'd1);
        check("preempt_pending", 32'(oam_dma_active), 32'd1);
        hdma_byte();
        hdma_active = 1'b0;
        tick();
        expect_gap("resume_gap");
        tick();
        oam_run(8'hFE, 40, 159);
        finish_oam();
        tick();

        // HDMA rise and FF46 write in the same ce; then restart at idx 100
        hdma_active = 1'b1;
        reg_sel = 1'b1;
        reg_wr = 1'b1;
        reg_din = 8'h12;
        settle();
        tick();
        reg_sel = 1'b0;
        reg_wr = 1'b0;
        expect_gap("simul_gap");
        check("simul_pending", 32'(oam_dma_active), 32'd1);
        tick();
        settle();
        check("simul_hdma_first", 32'(bus_owner), 32'd1);
        hdma_byte();
        hdma_active = 1'b0;
        tick();
        expect_gap("simul_to_oam_gap");
        tick();
        oam_run(8'h12, 0, 99);
        oam_phase(8'h12, 100, 0);
        oam_phase(8'h12, 100, 1);
        reg_sel = 1'b1;
        reg_wr = 1'b1;
        reg_din = 8'h80;
        oam_phase(8'h12, 100, 2);
        reg_sel = 1'b0;
        reg_wr = 1'b0;
        exp_q.delete();
        settle();
        check("restart_readback", 32'(reg_dout), 32'h80);
        oam_run(8'h80, 0, 159);
        finish_oam();
        tick();

        // FF46 write on the final byte's phase 3: restart wins
        s1 = 8'($urandom);
        s2 = 8'($urandom);
        start_oam(s1);
        oam_run(s1, 0, 158);
        oam_phase(s1, 159, 0);
        oam_phase(s1, 159, 1);
        oam_phase(s1, 159, 2);
        reg_sel = 1'b1;
        reg_wr = 1'b1;
        reg_din = s2;
        oam_phase(s1, 159, 3);
        reg_sel = 1'b0;
        reg_wr = 1'b0;
        settle();
        check("final_restart_pending", 32'(oam_dma_active), 32'd1);
        check("final_restart_reg", 32'(reg_dout), 32'(s2));
        oam_run(s2, 0, 159);
        finish_oam();
`else
        // Without the OAM engine FF46 writes have no effect
        reg_sel = 1'b1;
        reg_wr = 1'b1;
        reg_din = 8'($urandom_range(0, 254));
        settle();
        tick();
        reg_sel = 1'b0;
        reg_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("noen_reg_dout", 32'(reg_dout), 32'hFF);
            check("noen_active", 32'(oam_dma_active), 32'd0);
            check("noen_owner", 32'(bus_owner), 32'd0);
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
